// File: rtl/jtdd_adpcm_fetch_pkg.sv
// Shared types and widths for the ADPCM ROM prefetch buffer.
package jtdd_adpcm_fetch_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PREF  = 2'd2
  } state_t;

  // Little-endian byte pick: even address is the low byte.
  function automatic logic [BYTE_W-1:0] byte_sel(input logic [DATA_W-1:0] word,
                                                 input logic odd);
    return odd ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/jtdd_adpcm_fetch_if.sv
// Client byte-ROM port plus SDRAM word channel of the prefetch buffer.
interface jtdd_adpcm_fetch_if #(
  parameter int unsigned AW = 16
);
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          rom_ok;
  logic [AW-2:0] sdram_addr;
  logic          sdram_req;
  logic [15:0]   sdram_data;
  logic          sdram_ok;

  // Environment side: ADPCM player and SDRAM controller.
  modport master (
    output rom_cs, rom_addr, sdram_data, sdram_ok,
    input  rom_data, rom_ok, sdram_addr, sdram_req
  );

  // Buffer side.
  modport slave (
    input  rom_cs, rom_addr, sdram_data, sdram_ok,
    output rom_data, rom_ok, sdram_addr, sdram_req
  );
endinterface

// File: rtl/jtdd_adpcm_fetch_entry.sv
// One buffer entry: tag/valid/data registers and a hit comparator.
module jtdd_adpcm_fetch_entry
  import jtdd_adpcm_fetch_pkg::*;
#(
  parameter int unsigned TW = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inv,
  input  logic [TW-1:0]     wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [TW-1:0]     wa,
  output logic              valid,
  output logic [TW-1:0]     tag,
  output logic [DATA_W-1:0] data,
  output logic              hit_c
);

  // Load on fill completion; invalidate when chosen as the next fill target.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      tag   <= wr_tag;
      data  <= wr_data;
    end else if (inv) begin
      valid <= 1'b0;
    end
  end

  assign hit_c = valid && (tag == wa);

endmodule

// File: rtl/jtdd_adpcm_fetch.sv
// Two-entry prefetch buffer between the byte-wide ADPCM ROM port and SDRAM.
module jtdd_adpcm_fetch
  import jtdd_adpcm_fetch_pkg::*;
#(
  parameter int unsigned AW = 16
) (
  input logic               clk,
  input logic               rst_n,
  jtdd_adpcm_fetch_if.slave bus
);

  localparam int unsigned TW = AW - 1;

  state_t            state, state_nx;
  logic              req, mru, tgt;
  logic              issue, done, iss_tgt, other, other_holds;
  logic [TW-1:0]     req_addr, iss_addr, wa, wa_nx;
  logic [1:0]        valid, hit, load, inv;
  logic [TW-1:0]     tag  [2];
  logic [DATA_W-1:0] data [2];

  for (genvar i = 0; i < 2; i++) begin : g_entry
    jtdd_adpcm_fetch_entry #(.TW(TW)) u_entry (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load[i]),
      .inv     (inv[i]),
      .wr_tag  (req_addr),
      .wr_data (bus.sdram_data),
      .wa      (wa),
      .valid   (valid[i]),
      .tag     (tag[i]),
      .data    (data[i]),
      .hit_c   (hit[i])
    );
  end

  assign wa    = bus.rom_addr[AW-1:1];
  assign wa_nx = wa + TW'(1);
  assign load  = {done & tgt, done & ~tgt};
  assign inv   = {issue & iss_tgt, issue & ~iss_tgt};

  // The prefetch slot is whichever entry is not serving the current address.
  assign other       = hit[0];
  assign other_holds = valid[other] && (tag[other] == wa_nx);

  // Zero-latency hit path; E0 has priority if both entries match.
  assign bus.rom_ok   = bus.rom_cs & (|hit);
  assign bus.rom_data = hit[0] ? byte_sel(data[0], bus.rom_addr[0]) :
                        hit[1] ? byte_sel(data[1], bus.rom_addr[0]) : 8'h00;
  assign bus.sdram_req  = req;
  assign bus.sdram_addr = req_addr;

  // Next state: demand miss first, then sequential prefetch; never abort.
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    done     = 1'b0;
    iss_tgt  = tgt;
    iss_addr = req_addr;
    case (state)
      IDLE: begin
        if (bus.rom_cs) begin
          if (!(|hit)) begin
            state_nx = FETCH;
            issue    = 1'b1;
            iss_addr = wa;
            iss_tgt  = valid[0] ? ~mru : 1'b0;
          end else if (!other_holds) begin
            state_nx = PREF;
            issue    = 1'b1;
            iss_addr = wa_nx;
            iss_tgt  = other;
          end
        end
      end
      FETCH, PREF: begin
        if (bus.sdram_ok) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, request, target and most-recently-hit registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      req      <= 1'b0;
      req_addr <= '0;
      tgt      <= 1'b0;
      mru      <= 1'b0;
    end else begin
      state <= state_nx;
      req   <= (state_nx != IDLE);
      if (issue) begin
        req_addr <= iss_addr;
        tgt      <= iss_tgt;
      end
      if (bus.rom_cs && (|hit)) mru <= ~hit[0];
    end
  end

endmodule

// File: tb/tb_jtdd_adpcm_fetch.sv
// Self-checking bench for the ADPCM ROM prefetch buffer.
module tb_jtdd_adpcm_fetch;

  localparam int unsigned AW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtdd_adpcm_fetch_if #(.AW(AW)) bus ();

  jtdd_adpcm_fetch #(.AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 4;
  bit resp_en = 1'b0;
  int stray_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM contents as seen through SDRAM; word 0 reads 0xBEEF.
  function automatic logic [15:0] mem_word(input logic [14:0] a);
    return 16'hBEEF ^ 16'(32'(a) * 32'h3C5B);
  endfunction

  function automatic logic [7:0] mem_byte(input logic [15:0] ba);
    logic [15:0] w;
    w = mem_word(ba[15:1]);
    return ba[0] ? w[15:8] : w[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_ok(input string name, input int budget);
    int n;
    n = 0;
    while (bus.sdram_ok !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_ok_seen"}, 32'(bus.sdram_ok), 32'd1);
  endtask

  task automatic drain();
    int n;
    bus.rom_cs = 1'b0;
    n = 0;
    while (bus.sdram_req === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_idle", 32'(bus.sdram_req), 32'd0);
    tick();
  endtask

  // SDRAM responder: completes each request after lat cycles; can inject a stray pulse.
  initial begin
    int cnt;
    cnt = 0;
    bus.sdram_ok   = 1'b0;
    bus.sdram_data = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      bus.sdram_ok = 1'b0;
      if (cyc == stray_cyc) begin
        bus.sdram_ok   = 1'b1;
        bus.sdram_data = 16'hDEAD;
      end else if (resp_en && bus.sdram_req === 1'b1) begin
        cnt++;
        if (cnt >= lat) begin
          bus.sdram_ok   = 1'b1;
          bus.sdram_data = mem_word(bus.sdram_addr);
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        cs;
    logic [15:0] addr;
    logic        ok;
    logic [7:0]  data;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bit good;
    int n;
    logic        prev_req, prev_ok, cs;
    logic [14:0] prev_addr;
    logic [15:0] a;
    int hold, stuck;

    // Hits on words 0/1 (with E1 already holding word 1) and cs-gated lookups.
    tbl[0] = '{1'b1, 16'h0000, 1'b1, 8'hEF};
    tbl[1] = '{1'b1, 16'h0001, 1'b1, 8'hBE};
    tbl[2] = '{1'b0, 16'h0002, 1'b0, 8'h00};
    tbl[3] = '{1'b0, 16'h0003, 1'b0, 8'h00};
    tbl[4] = '{1'b0, 16'h0100, 1'b0, 8'h00};
    tbl[5] = '{1'b1, 16'h0000, 1'b1, 8'hEF};

    // Reset state and first demand fill.
    bus.rom_cs   = 1'b1;
    bus.rom_addr = 16'h0000;
    lat = 5;
    repeat (3) tick();
    #1;
    chk("rst_req", 32'(bus.sdram_req), 32'd0);
    chk("rst_addr", 32'(bus.sdram_addr), 32'd0);
    chk("rst_ok", 32'(bus.rom_ok), 32'd0);
    chk("rst_data", 32'(bus.rom_data), 32'd0);
    resp_en = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("t1_req", 32'(bus.sdram_req), 32'd1);
    chk("t1_addr", 32'(bus.sdram_addr), 32'd0);
    wait_ok("t1_fetch", 20);
    chk("t1_ok_before_fill", 32'(bus.rom_ok), 32'd0);
    tick();
    chk("t1_ok", 32'(bus.rom_ok), 32'd1);
    chk("t1_data", 32'(bus.rom_data), 32'hEF);
    chk("t1_req_gap", 32'(bus.sdram_req), 32'd0);
    tick();
    chk("t1_pref_req", 32'(bus.sdram_req), 32'd1);
    chk("t1_pref_addr", 32'(bus.sdram_addr), 32'd1);
    wait_ok("t1_pref", 20);
    tick();
    tick();

    // Table of lookups against the filled words 0 and 1.
    for (int i = 0; i < 6; i++) begin
      bus.rom_cs   = tbl[i].cs;
      bus.rom_addr = tbl[i].addr;
      #1;
      chk($sformatf("tbl%0d_ok", i), 32'(bus.rom_ok), 32'(tbl[i].ok));
      if (tbl[i].ok) chk($sformatf("tbl%0d_data", i), 32'(bus.rom_data), 32'(tbl[i].data));
      tick();
      chk($sformatf("tbl%0d_noreq", i), 32'(bus.sdram_req), 32'd0);
    end

    // Sequential sweep: prefetch must keep every byte available.
    lat = 4;
    bus.rom_cs = 1'b1;
    for (int b = 0; b < 256; b++) begin
      bus.rom_addr = 16'(b);
      good = 1'b1;
      for (int c = 0; c < 8; c++) begin
        #1;
        if (bus.rom_ok !== 1'b1 || bus.rom_data !== mem_byte(16'(b))) good = 1'b0;
        tick();
      end
      chk($sformatf("sweep_%0h", b), 32'(good), 32'd1);
    end

    // Prefetch address wraps from 0x7FFF to 0.
    drain();
    bus.rom_cs   = 1'b1;
    bus.rom_addr = 16'hFFFE;
    tick();
    chk("wrap_fetch_req", 32'(bus.sdram_req), 32'd1);
    chk("wrap_fetch_addr", 32'(bus.sdram_addr), 32'h7FFF);
    wait_ok("wrap_fetch", 20);
    tick();
    #1;
    chk("wrap_ok", 32'(bus.rom_ok), 32'd1);
    chk("wrap_data", 32'(bus.rom_data), 32'(mem_byte(16'hFFFE)));
    tick();
    chk("wrap_pref_req", 32'(bus.sdram_req), 32'd1);
    chk("wrap_pref_addr", 32'(bus.sdram_addr), 32'h0000);
    wait_ok("wrap_pref", 20);

    // Jump to 0x4000 while word 3 is being prefetched.
    drain();
    bus.rom_cs   = 1'b1;
    bus.rom_addr = 16'h0004;
    n = 0;
    while (!(bus.sdram_req === 1'b1 && bus.sdram_addr == 15'd3) && n < 40) begin
      tick();
      n++;
    end
    chk("jump_pref3", 32'(bus.sdram_addr), 32'd3);
    bus.rom_addr = 16'h4000;
    good = 1'b1;
    n = 0;
    while (bus.sdram_ok !== 1'b1 && n < 20) begin
      #1;
      if (bus.rom_ok !== 1'b0) good = 1'b0;
      tick();
      n++;
    end
    chk("jump_pref_done", 32'(bus.sdram_ok), 32'd1);
    chk("jump_pref_addr", 32'(bus.sdram_addr), 32'd3);
    tick();
    chk("jump_gap", 32'(bus.sdram_req), 32'd0);
    if (bus.rom_ok !== 1'b0) good = 1'b0;
    tick();
    chk("jump_fetch_req", 32'(bus.sdram_req), 32'd1);
    chk("jump_fetch_addr", 32'(bus.sdram_addr), 32'h2000);
    n = 0;
    while (bus.sdram_ok !== 1'b1 && n < 20) begin
      if (bus.rom_ok !== 1'b0) good = 1'b0;
      tick();
      n++;
    end
    chk("jump_fetch_done", 32'(bus.sdram_ok), 32'd1);
    chk("jump_no_early_ok", 32'(good), 32'd1);
    tick();
    #1;
    chk("jump_ok", 32'(bus.rom_ok), 32'd1);
    chk("jump_data", 32'(bus.rom_data), 32'(mem_byte(16'h4000)));

    // Reset during a request, then a stray completion must be ignored.
    drain();
    lat = 10;
    bus.rom_cs   = 1'b1;
    bus.rom_addr = 16'h1234;
    tick();
    chk("rstmid_req", 32'(bus.sdram_req), 32'd1);
    tick();
    rst_n = 1'b0;
    bus.rom_cs = 1'b0;
    resp_en = 1'b0;
    tick();
    chk("rstmid_drop", 32'(bus.sdram_req), 32'd0);
    tick();
    rst_n = 1'b1;
    stray_cyc = cyc + 2;
    tick();
    tick();
    chk("rstmid_idle", 32'(bus.sdram_req), 32'd0);
    tick();
    bus.rom_cs   = 1'b1;
    bus.rom_addr = 16'h0000;
    #1;
    chk("rstmid_nothing_stored", 32'(bus.rom_ok), 32'd0);
    tick();
    chk("rstmid_fresh_req", 32'(bus.sdram_req), 32'd1);
    chk("rstmid_fresh_addr", 32'(bus.sdram_addr), 32'd0);
    lat = 3;
    resp_en = 1'b1;
    wait_ok("rstmid_fetch", 20);
    tick();
    #1;
    chk("rstmid_ok", 32'(bus.rom_ok), 32'd1);
    chk("rstmid_data", 32'(bus.rom_data), 32'hEF);

    // Random traffic against ROM contents, handshake rules and a progress bound.
    drain();
    prev_req  = 1'b0;
    prev_ok   = 1'b0;
    prev_addr = '0;
    hold  = 0;
    stuck = 0;
    a  = 16'h0000;
    cs = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (i % 250 == 0) lat = $urandom_range(1, 6);
      if (prev_req && !prev_ok) begin
        chk("rand_req_held", 32'(bus.sdram_req), 32'd1);
        chk("rand_addr_stable", 32'(bus.sdram_addr), 32'(prev_addr));
      end
      if (prev_ok) chk("rand_req_drop", 32'(bus.sdram_req), 32'd0);
      prev_req  = bus.sdram_req;
      prev_ok   = bus.sdram_ok;
      prev_addr = bus.sdram_addr;
      if (hold == 0) begin
        hold = $urandom_range(1, 10);
        cs = ($urandom_range(0, 7) != 0);
        case ($urandom_range(0, 3))
          0: a = a + 16'd1;
          1: a = a + 16'd2;
          2: a = 16'($urandom_range(0, 63));
          default: a = 16'($urandom);
        endcase
        bus.rom_addr = a;
        bus.rom_cs   = cs;
        stuck = 0;
      end
      hold--;
      #1;
      if (!cs) begin
        chk("rand_cs_gate", 32'(bus.rom_ok), 32'd0);
      end else begin
        if (bus.rom_ok === 1'b1) chk("rand_data", 32'(bus.rom_data), 32'(mem_byte(a)));
        else stuck++;
        chk("rand_progress", 32'(stuck <= 24), 32'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
